// File: rtl/miriscv_wb_stage.sv
// miriscv_wb_stage: writeback stage picking ALU/MDU/LSU/CSR result and writing the register file.
// Optional feature macro: MIRISCV_WB_FWD_EN adds the forwarding outputs.
// Ports:
//   clk_i, arstn_i            clock, async active-low reset
//   ex_*                      instruction handshake and payload from execute
//   mdu_valid_i/mdu_result_i  MDU result pulse
//   lsu_valid_i/lsu_rdata_i   LSU load data pulse
//   kill_i                    flush held instruction
//   rf_we_o/rf_waddr_o/rf_wdata_o  register-file write port
//   busy_o                    stage holds an instruction
//   fwd_*                     forwarding view of the write port (MIRISCV_WB_FWD_EN only)
module miriscv_wb_stage #(
  parameter int XLEN      = 32,
  parameter int RF_ADDR_W = 5
) (
  input  logic                 clk_i,
  input  logic                 arstn_i,
  input  logic                 ex_valid_i,
  output logic                 ex_ready_o,
  input  logic [1:0]           ex_wb_src_i,
  input  logic                 ex_rd_we_i,
  input  logic [RF_ADDR_W-1:0] ex_rd_addr_i,
  input  logic [XLEN-1:0]      ex_alu_result_i,
  input  logic [XLEN-1:0]      ex_csr_rdata_i,
  input  logic                 mdu_valid_i,
  input  logic [XLEN-1:0]      mdu_result_i,
  input  logic                 lsu_valid_i,
  input  logic [XLEN-1:0]      lsu_rdata_i,
  input  logic                 kill_i,
  output logic                 rf_we_o,
  output logic [RF_ADDR_W-1:0] rf_waddr_o,
  output logic [XLEN-1:0]      rf_wdata_o,
  output logic                 busy_o
`ifdef MIRISCV_WB_FWD_EN
  ,
  output logic                 fwd_valid_o,
  output logic [RF_ADDR_W-1:0] fwd_addr_o,
  output logic [XLEN-1:0]      fwd_data_o,
  output logic                 fwd_pending_o
`endif
);
  typedef enum logic [1:0] {IDLE, WAIT, WRITE} state_e;
  localparam logic [1:0] SRC_ALU = 2'd0, SRC_MDU = 2'd1, SRC_LSU = 2'd2;
  state_e                 state_q, state_d;
  logic [1:0]             src_q, src_d;
  logic                   rd_we_q, rd_we_d;
  logic [RF_ADDR_W-1:0]   rd_addr_q, rd_addr_d, waddr_q, waddr_d;
  logic [XLEN-1:0]        wdata_q, wdata_d, unit_data;
  logic                   wen_q, wen_d, accept, unit_valid, need_unit;
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) state_q <= IDLE;
    else          state_q <= state_d;
  // WAIT only resolves on the held unit's pulse; kill overrides everything.
  always_comb
    state_d = kill_i             ? IDLE :
              (state_q == WAIT)  ? (unit_valid ? WRITE : WAIT) :
              accept             ? ((need_unit && !unit_valid) ? WAIT : WRITE) :
                                   IDLE;
  always_comb begin
    ex_ready_o = (state_q != WAIT) && !kill_i;
    busy_o     = state_q != IDLE;
    rf_we_o    = wen_q && !kill_i;
  end
  assign accept     = ex_valid_i && ex_ready_o;
  assign rf_waddr_o = waddr_q;
  assign rf_wdata_o = wdata_q;
  always_comb begin
    src_d      = accept ? ex_wb_src_i  : src_q;
    rd_we_d    = accept ? ex_rd_we_i   : rd_we_q;
    rd_addr_d  = accept ? ex_rd_addr_i : rd_addr_q;
    unit_valid = (src_d == SRC_MDU) ? mdu_valid_i : lsu_valid_i;
    need_unit  = rd_we_d && (src_d == SRC_MDU || src_d == SRC_LSU);
    unit_data  = (src_d == SRC_ALU) ? ex_alu_result_i :
                 (src_d == SRC_MDU) ? mdu_result_i :
                 (src_d == SRC_LSU) ? lsu_rdata_i : ex_csr_rdata_i;
    // Address/data registers only move for a real write so they never toggle while rf_we_o is low.
    wen_d      = (state_d == WRITE) && rd_we_d && (rd_addr_d != '0);
    waddr_d    = wen_d ? rd_addr_d : waddr_q;
    wdata_d    = wen_d ? unit_data : wdata_q;
  end
  always_ff @(posedge clk_i or negedge arstn_i)
    if (!arstn_i) begin
      src_q     <= '0;
      rd_we_q   <= 1'b0;
      rd_addr_q <= '0;
      wen_q     <= 1'b0;
      waddr_q   <= '0;
      wdata_q   <= '0;
    end else begin
      src_q     <= src_d;
      rd_we_q   <= rd_we_d;
      rd_addr_q <= rd_addr_d;
      wen_q     <= wen_d;
      waddr_q   <= waddr_d;
      wdata_q   <= wdata_d;
    end
`ifdef MIRISCV_WB_FWD_EN
  assign fwd_valid_o   = rf_we_o;
  assign fwd_addr_o    = rf_waddr_o;
  assign fwd_data_o    = rf_wdata_o;
  assign fwd_pending_o = (state_q == WAIT) && rd_we_q;
`endif
endmodule

// File: tb/tb_miriscv_wb_stage.sv
// tb_miriscv_wb_stage: directed vector bench for the writeback stage.
module tb_miriscv_wb_stage;
  logic        clk = 1'b0, arstn_i = 1'b0;
  logic        ex_valid_i, ex_ready_o, ex_rd_we_i, mdu_valid_i, lsu_valid_i, kill_i;
  logic [1:0]  ex_wb_src_i;
  logic [4:0]  ex_rd_addr_i, rf_waddr_o;
  logic [31:0] ex_alu_result_i, ex_csr_rdata_i, mdu_result_i, lsu_rdata_i, rf_wdata_o;
  logic        rf_we_o, busy_o;
  int          n_cmp = 0, n_err = 0;

  miriscv_wb_stage dut (
    .clk_i(clk), .arstn_i(arstn_i),
    .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o), .ex_wb_src_i(ex_wb_src_i),
    .ex_rd_we_i(ex_rd_we_i), .ex_rd_addr_i(ex_rd_addr_i),
    .ex_alu_result_i(ex_alu_result_i), .ex_csr_rdata_i(ex_csr_rdata_i),
    .mdu_valid_i(mdu_valid_i), .mdu_result_i(mdu_result_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rdata_i(lsu_rdata_i), .kill_i(kill_i),
    .rf_we_o(rf_we_o), .rf_waddr_o(rf_waddr_o), .rf_wdata_o(rf_wdata_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic v; logic [1:0] src; logic we; logic [4:0] rd;
    logic [31:0] alu, csr; logic mv; logic [31:0] md; logic lv; logic [31:0] ld; logic kill;
    logic e_rdy, e_we; logic [4:0] e_wa; logic [31:0] e_wd; logic e_busy;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(input logic v, input logic [1:0] src, input logic we, input logic [4:0] rd,
                              input logic [31:0] alu, input logic [31:0] csr,
                              input logic mv, input logic [31:0] md, input logic lv, input logic [31:0] ld,
                              input logic kill, input logic e_rdy, input logic e_we,
                              input logic [4:0] e_wa, input logic [31:0] e_wd, input logic e_busy);
    vec_t t;
    t.v = v; t.src = src; t.we = we; t.rd = rd; t.alu = alu; t.csr = csr;
    t.mv = mv; t.md = md; t.lv = lv; t.ld = ld; t.kill = kill;
    t.e_rdy = e_rdy; t.e_we = e_we; t.e_wa = e_wa; t.e_wd = e_wd; t.e_busy = e_busy;
    return t;
  endfunction

  // Idle inputs with the given expected outputs.
  function automatic vec_t idl(input logic r, input logic w, input logic [4:0] wa, input logic [31:0] wd,
                               input logic b);
    return mk(0, 0, 0, 0, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, r, w, wa, wd, b);
  endfunction

  task automatic apply(input vec_t t);
    ex_valid_i = t.v; ex_wb_src_i = t.src; ex_rd_we_i = t.we; ex_rd_addr_i = t.rd;
    ex_alu_result_i = t.alu; ex_csr_rdata_i = t.csr;
    mdu_valid_i = t.mv; mdu_result_i = t.md; lsu_valid_i = t.lv; lsu_rdata_i = t.ld; kill_i = t.kill;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic chk_all(input string tag, input logic r, input logic w, input logic [4:0] wa,
                         input logic [31:0] wd, input logic b);
    chk({tag, ".ready"}, {31'b0, ex_ready_o}, {31'b0, r});
    chk({tag, ".we"},    {31'b0, rf_we_o},    {31'b0, w});
    chk({tag, ".waddr"}, {27'b0, rf_waddr_o}, {27'b0, wa});
    chk({tag, ".wdata"}, rf_wdata_o,          wd);
    chk({tag, ".busy"},  {31'b0, busy_o},     {31'b0, b});
  endtask

  initial begin
    apply(idl(0, 0, 0, 0, 0));
    #1 chk_all("reset", 1, 0, 5'd0, 32'h0, 0);
    @(negedge clk) arstn_i = 1'b1;

    // ALU rd5 single-cycle writeback
    tv.push_back(mk(1, 0, 1, 5,  32'h1234, 32'hBAD0, 1, 32'hBAD1, 1, 32'hBAD2, 0, 1, 0, 0, 32'h0, 0));
    tv.push_back(idl(1, 1, 5, 32'h1234, 1));
    tv.push_back(idl(1, 0, 5, 32'h1234, 0));
    // LSU rd7 waits three cycles; MDU pulse while waiting is ignored
    tv.push_back(mk(1, 2, 1, 7,  32'hAAAA, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 5, 32'h1234, 0));
    tv.push_back(idl(0, 0, 5, 32'h1234, 1));
    tv.push_back(mk(0, 0, 0, 0,  32'h0, 32'h0, 1, 32'h99, 0, 32'h0, 0, 0, 0, 5, 32'h1234, 1));
    tv.push_back(mk(0, 0, 0, 0,  32'h0, 32'h0, 0, 32'h0, 1, 32'hDEADBEEF, 0, 0, 0, 5, 32'h1234, 1));
    tv.push_back(idl(1, 1, 7, 32'hDEADBEEF, 1));
    // MDU rd3 with result in the accept cycle
    tv.push_back(mk(1, 1, 1, 3,  32'hAAAA, 32'h0, 1, 32'h55, 1, 32'hBBBB, 0, 1, 0, 7, 32'hDEADBEEF, 0));
    tv.push_back(idl(1, 1, 3, 32'h55, 1));
    // ALU rd0: WRITE entered, no write
    tv.push_back(mk(1, 0, 1, 0,  32'hFFFF, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 3, 32'h55, 0));
    tv.push_back(idl(1, 0, 3, 32'h55, 1));
    tv.push_back(idl(1, 0, 3, 32'h55, 0));
    // Back-to-back ALU rd1,2,3
    tv.push_back(mk(1, 0, 1, 1,  32'h11, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 3, 32'h55, 0));
    tv.push_back(mk(1, 0, 1, 2,  32'h22, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 1, 32'h11, 1));
    tv.push_back(mk(1, 0, 1, 3,  32'h33, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 1, 2, 32'h22, 1));
    tv.push_back(idl(1, 1, 3, 32'h33, 1));
    tv.push_back(idl(1, 0, 3, 32'h33, 0));
    // CSR rd9
    tv.push_back(mk(1, 3, 1, 9,  32'hAAAA, 32'hC5C5, 1, 32'h1, 1, 32'h2, 0, 1, 0, 3, 32'h33, 0));
    tv.push_back(idl(1, 1, 9, 32'hC5C5, 1));
    // LSU with rd_we=0 goes straight to WRITE, no write
    tv.push_back(mk(1, 2, 0, 4,  32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 9, 32'hC5C5, 0));
    tv.push_back(idl(1, 0, 9, 32'hC5C5, 1));
    tv.push_back(idl(1, 0, 9, 32'hC5C5, 0));
    // Kill in WAIT, later LSU pulse is ignored
    tv.push_back(mk(1, 2, 1, 6,  32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 9, 32'hC5C5, 0));
    tv.push_back(idl(0, 0, 9, 32'hC5C5, 1));
    tv.push_back(mk(0, 0, 0, 0,  32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 9, 32'hC5C5, 1));
    tv.push_back(mk(0, 0, 0, 0,  32'h0, 32'h0, 0, 32'h0, 1, 32'h77, 0, 1, 0, 9, 32'hC5C5, 0));
    tv.push_back(idl(1, 0, 9, 32'hC5C5, 0));
    // Kill in WRITE suppresses the write and blocks a new accept
    tv.push_back(mk(1, 0, 1, 8,  32'h88, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 9, 32'hC5C5, 0));
    tv.push_back(mk(1, 0, 1, 10, 32'hAB, 32'h0, 0, 32'h0, 0, 32'h0, 1, 0, 0, 8, 32'h88, 1));
    tv.push_back(idl(1, 0, 8, 32'h88, 0));
    tv.push_back(idl(1, 0, 8, 32'h88, 0));
    // MDU rd2 waits one cycle for its pulse
    tv.push_back(mk(1, 1, 1, 2,  32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 1, 0, 8, 32'h88, 0));
    tv.push_back(mk(0, 0, 0, 0,  32'h0, 32'h0, 1, 32'h66, 0, 32'h0, 0, 0, 0, 8, 32'h88, 1));
    tv.push_back(idl(1, 1, 2, 32'h66, 1));
    tv.push_back(idl(1, 0, 2, 32'h66, 0));

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge clk);
      apply(tv[i]);
      #1 chk_all($sformatf("vec%0d", i), tv[i].e_rdy, tv[i].e_we, tv[i].e_wa, tv[i].e_wd, tv[i].e_busy);
    end

    // Async reset while in WAIT clears outputs without a clock edge
    @(negedge clk);
    apply(mk(1, 2, 1, 11, 32'h0, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
    @(negedge clk);
    apply(idl(0, 0, 0, 0, 0));
    #1 chk_all("wait_pre", 0, 0, 2, 32'h66, 1);
    #2 arstn_i = 1'b0;
    #1 chk_all("rst_wait", 1, 0, 0, 32'h0, 0);
    // First accept on the first edge after release
    @(negedge clk);
    arstn_i = 1'b1;
    apply(mk(1, 0, 1, 12, 32'hC0DE, 32'h0, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h0, 0));
    @(negedge clk);
    apply(idl(0, 0, 0, 0, 0));
    #1 chk_all("post_rst", 1, 1, 12, 32'hC0DE, 1);
    // Async reset during WRITE drops rf_we_o immediately
    #2 arstn_i = 1'b0;
    #1 chk_all("rst_write", 1, 0, 0, 32'h0, 0);
    @(negedge clk) arstn_i = 1'b1;
    @(negedge clk);
    #1 chk_all("idle_end", 1, 0, 0, 32'h0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
